// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with valid/ready byte intake and a per-frame latched baud divisor
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_W    = 20,
    parameter int MIN_BAUD  = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sel,
    input  logic [BAUD_W-1:0] i_baud,
    input  logic              i_tx_valid,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic              o_tx_ready,
    output logic              o_tx,
    output logic              o_tx_busy,
    output logic [3:0]        o_bit_cnt,
    output logic              o_baud_err
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [BAUD_W-1:0] r_cnt, w_cnt_nxt, r_baud_q, w_baud_q_nxt;
    logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
    logic r_tx, w_tx_nxt;
    logic w_valid_baud, w_hs, w_tick;
    assign w_valid_baud = i_baud >= BAUD_W'(MIN_BAUD);
    assign w_hs = i_tx_valid & o_tx_ready;
    assign w_tick = (r_state != IDLE) && (r_cnt == r_baud_q - 1'b1);
    // State and datapath registers; tx idles high out of reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_baud_q  <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_baud_q  <= w_baud_q_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
        end
    end
    // Next state: deselect aborts any frame, otherwise advance on bit-period ticks
    always_comb begin
        w_state_nxt = r_state;
        if (!i_sel)
            w_state_nxt = IDLE;
        else
            case (r_state)
                IDLE:    w_state_nxt = w_hs ? START : IDLE;
                START:   w_state_nxt = w_tick ? DATA : START;
                DATA:    w_state_nxt = (w_tick && r_bit_cnt == 4'(DATA_BITS)) ? STOP : DATA;
                STOP:    w_state_nxt = w_tick ? IDLE : STOP;
                default: w_state_nxt = IDLE;
            endcase
    end
    // Outputs and next datapath values; tx is precomputed from the next state so it is registered
    always_comb begin
        o_tx_ready    = i_rst_n & i_sel & w_valid_baud & (r_state == IDLE);
        o_baud_err    = i_sel & ~w_valid_baud;
        o_tx_busy     = r_state != IDLE;
        o_tx          = r_tx;
        o_bit_cnt     = r_bit_cnt;
        w_shift_nxt   = w_hs ? i_tx_data : (r_state == DATA && w_tick) ? r_shift >> 1 : r_shift;
        w_baud_q_nxt  = w_hs ? i_baud : r_baud_q;
        w_cnt_nxt     = (w_state_nxt == IDLE || w_hs || w_tick) ? '0 : r_cnt + 1'b1;
        w_bit_cnt_nxt = (w_state_nxt == IDLE) ? '0 : w_tick ? r_bit_cnt + 4'd1 : r_bit_cnt;
        w_tx_nxt      = (w_state_nxt == START) ? 1'b0 : (w_state_nxt == DATA) ? w_shift_nxt[0] : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a queue-based scoreboard and a cycle-accurate line monitor
module tb_uart_tx;
    logic clk = 0, rst_n = 0, sel = 0, tx_valid = 0;
    logic [19:0] baud = 20'd16;
    logic [7:0] tx_data = 8'h00;
    logic tx_ready, tx, tx_busy, baud_err;
    logic [3:0] bit_cnt;
    int errors = 0, checks = 0, cyc = 0;
    bit mon_en = 0, mon_busy = 0;
    typedef struct {logic [7:0] d; int b; int len;} exp_t;
    exp_t sb[$];
    int starts[$];

    uart_tx dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_baud(baud),
        .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
        .o_tx(tx), .o_tx_busy(tx_busy), .o_bit_cnt(bit_cnt), .o_baud_err(baud_err)
    );

    // Free-running clock
    always #5 clk = ~clk;
    // Cycle counter used to timestamp frame starts
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic fbit(logic [7:0] d, int j);
        return (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
    endfunction

    // Offer a byte, wait (bounded) for acceptance and record the expected frame; len=0 means a full frame
    task automatic send(logic [7:0] d, bit hold, int len);
        int n = 0;
        tx_data = d;
        tx_valid = 1;
        #1;
        while (!tx_ready && n < 1000) begin
            tick(1);
            n++;
        end
        if (n >= 1000) begin
            chk("handshake_timeout", 1, 0);
            tx_valid = 0;
        end else begin
            sb.push_back('{d, int'(baud), (len == 0) ? 10 * int'(baud) : len});
            tick(1);
            if (!hold) tx_valid = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 2000) begin
            tick(1);
            n++;
        end
        chk("drain_timeout", int'(n >= 2000), 0);
    endtask

    // Monitor: on each start bit pop the expected frame and check every cycle of it, then the idle state
    initial begin
        exp_t e;
        int bad_tx, bad_bc;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                mon_busy = 1;
                starts.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    while (tx === 1'b0) @(negedge clk);
                end else begin
                    e = sb.pop_front();
                    bad_tx = 0;
                    bad_bc = 0;
                    for (int k = 0; k < e.len; k++) begin
                        if (k > 0) @(negedge clk);
                        if (tx !== fbit(e.d, k / e.b) || tx_busy !== 1'b1 || tx_ready !== 1'b0) bad_tx++;
                        if (bit_cnt !== 4'(k / e.b)) bad_bc++;
                    end
                    @(negedge clk);
                    chk("frame_tx_bad_cycles", bad_tx, 0);
                    chk("frame_bit_cnt_bad_cycles", bad_bc, 0);
                    chk("frame_end_tx_busy_cnt_ready", int'({tx, tx_busy, bit_cnt, tx_ready}), int'({1'b1, 1'b0, 4'd0, 1'b1}));
                end
                mon_busy = 0;
            end
        end
    end

    // Hard time limit so the bench always terminates
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Directed stimulus
    initial begin
        rst_n = 0; sel = 1; baud = 16; tx_valid = 1; tx_data = 8'hA5;
        tick(3);
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(tx_ready), 0);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        chk("rst_baud_err", int'(baud_err), 0);
        mon_en = 1;
        tick(5);
        chk("rst_hold_tx", int'(tx), 1);
        chk("rst_hold_busy", int'(tx_busy), 0);
        tx_valid = 0;
        rst_n = 1;
        tick(2);
        chk("idle_ready", int'(tx_ready), 1);
        send(8'hA5, 0, 0);
        drain();
        baud = 15;
        starts.delete();
        send(8'h00, 1, 0);
        send(8'hFF, 0, 0);
        drain();
        chk("b2b_frames", starts.size(), 2);
        if (starts.size() == 2) chk("b2b_start_gap", starts[1] - starts[0], 151);
        baud = 14; tx_data = 8'h5A; tx_valid = 1;
        tick(20);
        chk("badbaud_err", int'(baud_err), 1);
        chk("badbaud_ready", int'(tx_ready), 0);
        chk("badbaud_tx", int'(tx), 1);
        chk("badbaud_busy", int'(tx_busy), 0);
        baud = 15;
        #1;
        chk("goodbaud_err", int'(baud_err), 0);
        chk("goodbaud_ready", int'(tx_ready), 1);
        sb.push_back('{8'h5A, 15, 150});
        tick(1);
        tx_valid = 0;
        drain();
        baud = 16;
        send(8'h3C, 0, 4 * 16 + 4);
        tick(4 * 16 + 3);
        sel = 0;
        #1;
        chk("desel_ready", int'(tx_ready), 0);
        tick(1);
        sel = 1;
        drain();
        send(8'hC3, 0, 9 * 16 + 6);
        tick(9 * 16 + 5);
        rst_n = 0;
        #1;
        chk("midrst_ready", int'(tx_ready), 0);
        tick(1);
        rst_n = 1;
        drain();
        send(8'h96, 0, 0);
        tick(50);
        baud = 40;
        send(8'h69, 0, 0);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the binary UART: accepts a byte over a valid/ready handshake and shifts out a 10-bit frame (1 start bit, 8 data bits LSB first, 1 stop bit) on `tx`. The bit period is set in system clocks by the same 20-bit `baud` divisor word the receive side uses. The block sits between the host/register interface and the TX pin, opposite the UART receive path.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `BAUD_W`, 20: width of the baud divisor.
- `MIN_BAUD`, 15: smallest legal divisor; below this, `baud` is invalid.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `sel` in 1: block select. Low means standby; high means enabled.
- `baud` in BAUD_W: clocks per bit period.
- `tx_valid` in 1: a byte is offered on `tx_data`.
- `tx_data` in DATA_BITS: byte to send.
- `tx_ready` out 1: the block can accept a byte this cycle.
- `tx` out 1: serial line. It idles high.
- `tx_busy` out 1: a frame is in progress.
- `bit_cnt` out 4: current bit index. 0 is the start bit, 1–8 are data bits 0–7, 9 is the stop bit.
- `baud_err` out 1: asserted when `sel` is high and `baud` < `MIN_BAUD`.

## Operation
- States: IDLE, START, DATA, STOP. State, shift register, baud counter, `bit_cnt`, `baud_q` and `tx` are all registered.
- Validity check: `valid_baud` = (`baud` >= `MIN_BAUD`).
- `tx_ready` is combinational and equals `rst_n` & `sel` & `valid_baud` & (state == IDLE).
- `baud_err` is combinational and equals `sel` & ~`valid_baud`.
- Accepting a byte (handshake = `tx_valid` & `tx_ready`):
  - `tx_data` is latched into the shift register.
  - `baud` is latched into `baud_q`; later changes to `baud` do not affect the frame in flight.
  - The baud counter is cleared.
  - State moves to START.
- Baud counter: counts 0 to `baud_q`-1. At the terminal count it wraps to 0 and the bit advances.
- Bit advance:
  - START goes to DATA with `bit_cnt`=1.
  - In DATA, each advance shifts the register right and increments `bit_cnt`.
  - After bit 8, DATA goes to STOP with `bit_cnt`=9.
  - At the end of STOP, state returns to IDLE and `bit_cnt` returns to 0.
- `tx` per state: 0 in START, shift-register bit 0 in DATA, 1 in STOP and IDLE.
- `tx_busy` = (state != IDLE).
- `sel` low in any state: return to IDLE on the next edge with `tx`=1 and `bit_cnt`=0. The frame is aborted and not resumed.
- `baud` going invalid mid-frame: no effect on the frame in flight, because it uses `baud_q`. A new frame cannot start until `baud` is valid again.
- `tx_valid` outside IDLE: ignored. No queuing.

## Timing
- Reset (`rst_n` low at an edge) forces state to IDLE. Output values:
  - `tx`=1, `tx_busy`=0, `bit_cnt`=0, baud counter=0, `baud_q`=0.
  - `tx_ready`=0 while `rst_n` is low.
  - `baud_err` follows its equation.
- Reset mid-frame: `tx` returns to 1 at that edge and the partial frame is dropped.
- Let the handshake occur at edge E0.
  - `tx` goes to 0 after E0 and holds for `baud_q` clocks.
  - Each data bit then holds for `baud_q` clocks, followed by the stop bit for `baud_q` clocks.
  - The frame occupies exactly 10·`baud_q` clocks after E0.
  - IDLE, with `tx_ready` high, is reached at E0 + 10·`baud_q`.
- Back-to-back: if `tx_valid` is held, the next handshake occurs in the first IDLE cycle. Minimum frame-to-frame period is 10·`baud_q`+1 clocks, so there is one idle-high cycle between frames.
- Latency from handshake to the falling edge of the start bit: 1 clock.

## Test plan
- **Reset state:** `rst_n`=0 with `sel`=1, `baud`=16, `tx_valid`=1 → `tx`=1, `tx_ready`=0, `tx_busy`=0, `bit_cnt`=0; no frame starts.
- **Single frame:** `baud`=16, send 0xA5.
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each level held 16 clocks.
  - `bit_cnt` steps 0..9.
  - `tx_ready` returns high 160 clocks after the handshake.
- **Back-to-back:** `baud`=15, `tx_valid` held, send 0x00 then 0xFF.
  - Frame 1 is start, eight 0s, stop.
  - Exactly one idle-high clock follows.
  - Frame 2 is start, eight 1s, stop.
  - Total 301 clocks.
- **Invalid baud:** `sel`=1, `baud`=14, `tx_valid`=1 → `baud_err`=1, `tx_ready`=0, `tx`=1 indefinitely. Setting `baud`=15 gives a handshake on the next cycle.
- **Abort:**
  - `sel` dropped during data bit 3 → next edge: `tx`=1, `bit_cnt`=0, `tx_busy`=0.
  - `rst_n` pulsed low mid-stop-bit → same result.
- **Divisor change mid-frame:** `baud` changed from 16 to 40 mid-frame → the current frame keeps 16-clock bits; the next frame uses 40-clock bits.
